// File: rtl/alu_sched.sv
// Shares one combinational ALU between NREQ requesters: round-robin arbitration with
// an optional bounded lock, a registered result return, and the architectural NZCV register.
module alu_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*4-1:0] req_aluop,
  input  logic [NREQ*DW-1:0] req_opa,
  input  logic [NREQ*DW-1:0] req_opb,
  input  logic [NREQ-1:0]   req_flagin,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        alu_aluop,
  output logic [DW-1:0]     alu_opa,
  output logic [DW-1:0]     alu_opb,
  input  logic [DW-1:0]     alu_result,
  input  logic [3:0]        alu_flag_raw,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_result,
  output logic [3:0]        flag,
  output logic              locked,
  output logic [2:0]        owner
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t        state, stateNxt;
  logic [IW-1:0] rrPtr, ptrNxt;
  logic [IW-1:0] ownerQ, ownerNxt;
  logic [CW-1:0] lockCnt, cntNxt;
  logic [IW-1:0] win;
  logic          winValid;
  logic          found;
  int unsigned   cand;
  int unsigned   base;

  // Arbitration, lock sequencing and ALU operand steering.
  always_comb begin
    stateNxt  = state;
    ptrNxt    = rrPtr;
    ownerNxt  = ownerQ;
    cntNxt    = lockCnt;
    win       = ownerQ;
    winValid  = 1'b0;
    found     = 1'b0;
    cand      = 0;
    base      = 0;
    gnt       = '0;
    alu_aluop = '0;
    alu_opa   = '0;
    alu_opb   = '0;

    case (state)
      ARB: begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          cand = 32'(rrPtr) + k;
          if (cand >= NREQ) cand = cand - NREQ;
          if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
          end
        end
        if (found) begin
          winValid = 1'b1;
          ptrNxt   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          ownerNxt = win;
          if (req_lock[win]) begin
            stateNxt = LOCK;
            cntNxt   = '0;
          end
        end
      end
      LOCK: begin
        // lockCnt counts grants made while locked; the budget ends the chain without a grant.
        if (lockCnt == CW'(LOCK_MAX) || !req[ownerQ]) begin
          stateNxt = ARB;
        end else begin
          winValid = 1'b1;
          if (req_lock[ownerQ]) cntNxt = lockCnt + 1'b1;
          else                  stateNxt = ARB;
        end
      end
      default: stateNxt = ARB;
    endcase

    if (rst) winValid = 1'b0;

    if (winValid) begin
      base      = 32'(win);
      gnt[win]  = 1'b1;
      alu_aluop = req_aluop[base*4 +: 4];
      alu_opa   = req_opa[base*DW +: DW];
      alu_opb   = req_opb[base*DW +: DW];
    end
  end

  // State, pointer, response and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      rrPtr      <= '0;
      ownerQ     <= '0;
      lockCnt    <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      flag       <= '0;
    end else begin
      state     <= stateNxt;
      rrPtr     <= ptrNxt;
      ownerQ    <= ownerNxt;
      lockCnt   <= cntNxt;
      rsp_valid <= gnt;
      if (winValid) rsp_result <= alu_result;
      if (winValid && req_flagin[win]) flag <= alu_flag_raw;
    end
  end

  assign locked = (state == LOCK);
  assign owner  = 3'(ownerQ);

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: a queue-based arbitration model predicts grants,
// and a negedge monitor checks every returned response against the queue.
module tb_alu_sched;

  localparam int NREQ     = 4;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 8;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0, req_lock = '0, req_flagin = '0;
  logic [NREQ*4-1:0] req_aluop = '0;
  logic [NREQ*DW-1:0] req_opa = '0, req_opb = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [3:0]        alu_aluop, alu_flag_raw, flag;
  logic [DW-1:0]     alu_opa, alu_opb, alu_result, rsp_result;
  logic              locked;
  logic [2:0]        owner;

  alu_sched #(.NREQ(NREQ), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_aluop(req_aluop),
    .req_opa(req_opa), .req_opb(req_opb), .req_flagin(req_flagin), .gnt(gnt),
    .alu_aluop(alu_aluop), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_result(alu_result), .alu_flag_raw(alu_flag_raw), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .flag(flag), .locked(locked), .owner(owner)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {N,Z,C,V,result}; C on subtract means borrow.
  function automatic logic [35:0] aluFn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0; s = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b; c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_flag_raw, alu_result} = aluFn(alu_aluop, alu_opa, alu_opb);

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Requester state: each holds one pending op until granted.
  bit          pend[NREQ];
  bit          lk[NREQ];
  bit          fi[NREQ];
  logic [3:0]  op[NREQ];
  logic [31:0] opA[NREQ];
  logic [31:0] opB[NREQ];

  // Model state: rotation pointer, owner, lock chain status and architectural flags.
  int          ptrM, ownM, runM;
  bit          inLockM;
  logic [3:0]  flagM;
  logic [NREQ-1:0] lastGnt;
  logic        lastLocked;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [NREQ-1:0] ev;
    if (!rst && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none outstanding", rsp_valid);
      end else begin
        e = sb.pop_front();
        ev = '0;
        ev[e.idx] = 1'b1;
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_flag", 64'(flag), 64'(e.fl));
        chk("rsp_latency", 64'(cyc), 64'(e.cyc + 1));
      end
    end
  end

  function automatic void setOp(input int i, input logic [3:0] o, input logic [31:0] a,
                                input logic [31:0] b, input bit f, input bit l);
    pend[i] = 1'b1; op[i] = o; opA[i] = a; opB[i] = b; fi[i] = f; lk[i] = l;
  endfunction

  // One cycle: drive requests, predict the grant, check, and push the expected response.
  task automatic step(input bit adv);
    int win;
    logic [NREQ-1:0] eg;
    logic [35:0] r;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = pend[i];
      req_lock[i] = lk[i];
      req_flagin[i] = fi[i];
      req_aluop[i*4 +: 4] = op[i];
      req_opa[i*DW +: DW] = opA[i];
      req_opb[i*DW +: DW] = opB[i];
    end
    #1;
    lastLocked = locked;
    chk("locked", 64'(locked), 64'(inLockM));
    chk("owner", 64'(owner), 64'(ownM));
    chk("flag", 64'(flag), 64'(flagM));
    win = -1;
    if (inLockM) begin
      if (runM < LOCK_MAX && pend[ownM]) begin
        win = ownM;
        if (lk[ownM]) runM++;
        else inLockM = 1'b0;
      end else begin
        inLockM = 1'b0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && pend[(ptrM + k) % NREQ]) win = (ptrM + k) % NREQ;
      if (win >= 0) begin
        ptrM = (win + 1) % NREQ;
        ownM = win;
        if (lk[win]) begin
          inLockM = 1'b1;
          runM = 0;
        end
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    lastGnt = gnt;
    chk("gnt", 64'(gnt), 64'(eg));
    if (win >= 0) begin
      r = aluFn(op[win], opA[win], opB[win]);
      if (fi[win]) flagM = r[35:32];
      sb.push_back('{idx: win, res: r[31:0], fl: flagM, cyc: cyc});
      pend[win] = 1'b0;
    end
    if (adv) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    ptrM = 0; ownM = 0; runM = 0; inLockM = 1'b0; flagM = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; lk[i] = 1'b0; fi[i] = 1'b0; op[i] = '0; opA[i] = '0; opB[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int gseq[5];
    doReset();

    // Single add with flag update; result returns one cycle later.
    chk("reset_flag", 64'(flag), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    setOp(0, OP_ADD, 32'd5, 32'd7, 1'b1, 1'b0);
    step(1);
    chk("add_gnt", 64'(lastGnt), 64'h1);
    chk("add_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("add_rsp_result", 64'(rsp_result), 64'd12);
    chk("add_flag", 64'(flag), 64'h0);
    step(1);

    // Full contention, no locks: strict rotation.
    doReset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) setOp(i, OP_XOR, $urandom, $urandom, 1'b0, 1'b0);
      step(1);
      chk("rotate_gnt", 64'(lastGnt), 64'(1 << (c % NREQ)));
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    step(1);

    // Flag update only when flagin is set.
    doReset();
    setOp(2, OP_SUB, 32'd3, 32'd3, 1'b1, 1'b0);
    step(1);
    chk("sub_flag", 64'(flag), 64'h4);
    setOp(1, OP_AND, 32'hF0, 32'h0F, 1'b0, 1'b0);
    step(1);
    chk("and_flag_hold", 64'(flag), 64'h4);
    chk("and_rsp_result", 64'(rsp_result), 64'd0);
    step(1);

    // Requester 1 holds the lock for a short chain while requester 3 waits.
    doReset();
    setOp(3, OP_OR, 32'h1, 32'h2, 1'b0, 1'b0);
    cnt = 0;
    for (int s = 0; s < 5; s++) begin
      if (s < 4 && !pend[1]) setOp(1, OP_ADD, $urandom, $urandom, 1'b1, (s < 3));
      step(1);
      gseq[s] = int'(lastGnt);
      if (lastLocked) cnt++;
    end
    chk("lock_g0", 64'(gseq[0]), 64'h2);
    chk("lock_g3", 64'(gseq[3]), 64'h2);
    chk("lock_g4", 64'(gseq[4]), 64'h8);
    chk("lock_cycles", 64'(cnt), 64'd3);
    step(1);

    // Continuous lock by requester 0 hits the budget; requester 2 is served next.
    doReset();
    setOp(2, OP_SUB, 32'd9, 32'd4, 1'b0, 1'b0);
    cnt = 0;
    for (int s = 0; s < 11; s++) begin
      if (!pend[0]) setOp(0, OP_ADD, $urandom, $urandom, 1'b1, 1'b1);
      step(1);
      if (lastGnt == 4'h1) cnt++;
      if (s == 9)  chk("forced_release_gnt", 64'(lastGnt), 64'h0);
      if (s == 10) chk("after_release_gnt", 64'(lastGnt), 64'h4);
    end
    chk("lock_budget_grants", 64'(cnt), 64'd9);

    // Reset lands between a grant and its response edge.
    doReset();
    for (int i = 0; i < NREQ; i++) setOp(i, OP_ADD, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("gnt_in_reset", 64'(gnt), 64'h0);
    doReset();
    chk("rst_flag", 64'(flag), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    step(1);
    step(1);
    for (int i = 0; i < NREQ; i++) setOp(i, OP_AND, $urandom, $urandom, 1'b0, 1'b0);
    step(1);
    chk("post_rst_first_gnt", 64'(lastGnt), 64'h1);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    step(1);

    // Randomized traffic with random locks and flag updates.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0)
            setOp(i, 4'($urandom_range(1, 5)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
          else
            lk[i] = 1'($urandom_range(0, 1));
        end
      end
      step(1);
    end
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      lk[i] = 1'b0;
    end
    step(1);
    step(1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
